// File: rtl/tsc_pkg.sv
// Shared types and sizing for the timestamp-capture readout controller.
package tsc_pkg;

   localparam int unsigned TS_WIDTH_DEF = 32;
   localparam int unsigned BYTES_PER_TS = TS_WIDTH_DEF / 8;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_SEND    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Bytes needed to serialize one timestamp of width w
   function automatic int unsigned bytes_per(input int unsigned w);
      return w / 8;
   endfunction

endpackage

// File: rtl/tsc_ring_buf.sv
// Ring buffer of captured timestamps: write at head with overwrite-on-full,
// read at tail with pop. count tracks occupancy so full and empty are distinct.
// Ports:
//   clk, reset       clock, synchronous active-high reset (empties the buffer)
//   wr_en, wr_data   push a timestamp; when full the oldest entry is dropped
//   pop              discard the entry at tail
//   rd_data          entry at tail (oldest)
//   count            entries held, 0..DEPTH
//   full             count == DEPTH
module tsc_ring_buf
   import tsc_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned TS_WIDTH = TS_WIDTH_DEF,
   parameter int unsigned PTR_W    = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [TS_WIDTH-1:0] wr_data,
   input  logic                pop,
   output logic [TS_WIDTH-1:0] rd_data,
   output logic [PTR_W:0]      count,
   output logic                full
);

   logic [TS_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    head_q;
   logic [PTR_W-1:0]    tail_q;
   logic [PTR_W:0]      count_q;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign count   = count_q;
   assign rd_data = mem[tail_q];

   // Storage carries no reset; only the pointers define validity
   always_ff @(posedge clk) begin
      if (wr_en) mem[head_q] <= wr_data;
   end

   // Pointers wrap naturally at DEPTH (power of two). Writes and pops never
   // coincide: the controller writes only while capturing and pops only while draining.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) head_q <= head_q + PTR_W'(1);
         if (pop || (wr_en && full)) tail_q <= tail_q + PTR_W'(1);
         if (wr_en && !full)         count_q <= count_q + (PTR_W+1)'(1);
         else if (pop)               count_q <= count_q - (PTR_W+1)'(1);
      end
   end

endmodule

// File: rtl/tsc_readout_ctrl.sv
// Timestamp-capture controller: runs the timestamp timer, captures it into a
// ring buffer on trigger rising edges, and drains the buffer oldest-first as an
// MS-byte-first stream over a request_to_send/ack handshake.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, stop       enter / leave capturing (RUNNING)
//   trig              trigger; rising edge captures the timer while RUNNING
//   send_buf          request a drain of the buffer
//   ack               consumer accepts the offered byte
//   request_to_send   byte offered on data_out
//   data_out          current byte (0 when nothing offered)
//   complete_data     one-cycle pulse when a drain finishes
//   ready, running    commands accepted / capturing
//   count, overflow   buffer occupancy / entry lost since last drain (sticky)
module tsc_readout_ctrl
   import tsc_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned TS_WIDTH = TS_WIDTH_DEF,
   parameter int unsigned PTR_W    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             trig,
   input  logic             send_buf,
   input  logic             ack,
   output logic             request_to_send,
   output logic [7:0]       data_out,
   output logic             complete_data,
   output logic             ready,
   output logic             running,
   output logic [PTR_W:0]   count,
   output logic             overflow
);

   localparam int unsigned BYTES  = bytes_per(TS_WIDTH);
   localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   state_t              state_q, state_d;
   state_t              ret_q, ret_d;
   logic [TS_WIDTH-1:0] timer_q;
   logic                trig_q;
   logic [BIDX_W-1:0]   byte_idx_q;
   logic                rts_q, rts_d;
   logic                complete_q;
   logic                ready_q;
   logic                running_q;
   logic                overflow_q;
   logic                timer_clr;
   logic [TS_WIDTH-1:0] rb_rd_data;
   logic [PTR_W:0]      rb_count;
   logic                rb_full;
   logic [7:0]          byte_c;

   wire trig_edge  = trig & ~trig_q;
   wire capture    = trig_edge && (state_q == ST_RUNNING);
   wire last_byte  = (byte_idx_q == BIDX_W'(BYTES - 1));
   wire last_entry = (rb_count == (PTR_W+1)'(1));
   wire xfer       = (state_q == ST_SEND) && rts_q && ack;
   wire pop        = xfer && last_byte;
   wire timer_run  = (state_q == ST_RUNNING) ||
                     (((state_q == ST_SEND) || (state_q == ST_DONE)) && (ret_q == ST_RUNNING));

   tsc_ring_buf #(
      .DEPTH    (DEPTH),
      .TS_WIDTH (TS_WIDTH),
      .PTR_W    (PTR_W)
   ) u_ring_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (capture),
      .wr_data (timer_q),
      .pop     (pop),
      .rd_data (rb_rd_data),
      .count   (rb_count),
      .full    (rb_full)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      rts_d     = 1'b0;
      timer_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (send_buf) begin
               state_d = ST_SEND;
               ret_d   = ST_IDLE;
               rts_d   = (rb_count != '0);
            end else if (start) begin
               state_d   = ST_RUNNING;
               timer_clr = 1'b1;
            end
         end
         ST_RUNNING: begin
            if (send_buf) begin
               state_d = ST_SEND;
               ret_d   = ST_RUNNING;
               // a capture on this edge joins the drain
               rts_d   = (rb_count != '0) || capture;
            end else if (stop) begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (!rts_q) begin
               state_d = ST_DONE;
            end else if (ack && last_byte && last_entry) begin
               state_d = ST_DONE;
            end else begin
               rts_d = 1'b1;
            end
         end
         ST_DONE: state_d = ret_q;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ret_q      <= ST_IDLE;
         timer_q    <= '0;
         trig_q     <= 1'b0;
         byte_idx_q <= '0;
         rts_q      <= 1'b0;
         complete_q <= 1'b0;
         ready_q    <= 1'b1;
         running_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         trig_q     <= trig;
         rts_q      <= rts_d;
         complete_q <= (state_d == ST_DONE);
         ready_q    <= (state_d == ST_IDLE) || (state_d == ST_RUNNING);
         running_q  <= (state_d == ST_RUNNING);

         if (timer_clr)      timer_q <= '0;
         else if (timer_run) timer_q <= timer_q + TS_WIDTH'(1);

         if (state_q != ST_SEND) byte_idx_q <= '0;
         else if (xfer)          byte_idx_q <= last_byte ? '0 : byte_idx_q + BIDX_W'(1);

         if (state_q == ST_DONE)       overflow_q <= 1'b0;
         else if (capture && rb_full)  overflow_q <= 1'b1;
      end
   end

   // Byte select, most-significant byte first
   always_comb begin
      byte_c = 8'h00;
      for (int i = 0; i < BYTES; i++) begin
         if (byte_idx_q == BIDX_W'(BYTES - 1 - i)) byte_c = rb_rd_data[i*8 +: 8];
      end
   end

   assign request_to_send = rts_q;
   assign data_out        = rts_q ? byte_c : 8'h00;
   assign complete_data   = complete_q;
   assign ready           = ready_q;
   assign running         = running_q;
   assign count           = rb_count;
   assign overflow        = overflow_q;

endmodule

// File: tb/tb_tsc_readout_ctrl.sv
// Scoreboard bench for tsc_readout_ctrl: the stimulus pushes the hand-computed
// byte stream for each drain; a monitor pops and compares on every accepted byte.
module tb_tsc_readout_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, stop, trig, send_buf, ack;
   logic       request_to_send, complete_data, ready, running, overflow;
   logic [7:0] data_out;
   logic [3:0] count;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   tsc_readout_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .stop            (stop),
      .trig            (trig),
      .send_buf        (send_buf),
      .ack             (ack),
      .request_to_send (request_to_send),
      .data_out        (data_out),
      .complete_data   (complete_data),
      .ready           (ready),
      .running         (running),
      .count           (count),
      .overflow        (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
   endtask

   task automatic push_ts(input logic [31:0] v);
      for (int i = 3; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
   endtask

   task automatic wait_complete(input string name, input int max_cycles);
      bit seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clk);
         if (complete_data) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s: complete_data not seen within %0d cycles", name, max_cycles);
      end
   endtask

   // Monitor: compares each accepted byte against the scoreboard and checks stall stability
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_rts", 32'(request_to_send), 32'd1);
            check("stall_data", 32'(data_out), 32'(prev_data));
         end
         if (request_to_send && ack) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got %0h, expected no byte", data_out);
            end else begin
               check("byte", 32'(data_out), 32'(exp_q.pop_front()));
            end
         end
         prev_stall = request_to_send && !ack;
         prev_data  = data_out;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; trig = 1'b0; send_buf = 1'b0; ack = 1'b0;
      tick(); tick();
      @(negedge clk);
      check("rst_rts", 32'(request_to_send), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_complete", 32'(complete_data), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      tick();
      reset = 1'b0;

      // 1: captures at timer 5 and 9, drain from IDLE with ack held
      start = 1'b1; tick(); start = 1'b0;
      @(negedge clk);
      check("t1_running", 32'(running), 32'd1);
      repeat (5) tick();
      pulse_trig();
      tick(); tick();
      pulse_trig();
      @(negedge clk);
      check("t1_count2", 32'(count), 32'd2);
      stop = 1'b1; tick(); stop = 1'b0;
      @(negedge clk);
      check("t1_stopped", 32'(running), 32'd0);
      push_ts(32'd5); push_ts(32'd9);
      ack = 1'b1; send_buf = 1'b1; tick(); send_buf = 1'b0;
      @(negedge clk);
      check("t1_ready_send", 32'(ready), 32'd0);
      check("t1_rts_first", 32'(request_to_send), 32'd1);
      wait_complete("t1_complete", 20);
      check("t1_count0", 32'(count), 32'd0);
      check("t1_q_empty", 32'(exp_q.size()), 32'd0);
      tick();
      @(negedge clk);
      check("t1_idle_ready", 32'(ready), 32'd1);
      check("t1_idle_running", 32'(running), 32'd0);
      ack = 1'b0;

      // 2: multi-byte timestamps (0x12C, 0x12E) with a 3-cycle ack stall mid-entry
      start = 1'b1; tick(); start = 1'b0;
      repeat (300) tick();
      pulse_trig();
      pulse_trig();
      stop = 1'b1; tick(); stop = 1'b0;
      push_ts(32'h12C); push_ts(32'h12E);
      ack = 1'b1; send_buf = 1'b1; tick(); send_buf = 1'b0;
      tick();
      tick(); ack = 1'b0;
      repeat (3) tick();
      ack = 1'b1;
      wait_complete("t2_complete", 20);
      check("t2_q_empty", 32'(exp_q.size()), 32'd0);
      tick();
      ack = 1'b0;

      // 3: ten captures at 0,2,..,18 into 8 entries -> oldest two lost
      start = 1'b1; tick(); start = 1'b0;
      repeat (10) pulse_trig();
      @(negedge clk);
      check("t3_count_full", 32'(count), 32'd8);
      check("t3_overflow", 32'(overflow), 32'd1);
      stop = 1'b1; tick(); stop = 1'b0;
      for (int v = 4; v <= 18; v += 2) push_ts(32'(v));
      ack = 1'b1; send_buf = 1'b1; tick(); send_buf = 1'b0;
      wait_complete("t3_complete", 80);
      check("t3_q_empty", 32'(exp_q.size()), 32'd0);
      tick();
      @(negedge clk);
      check("t3_overflow_clr", 32'(overflow), 32'd0);
      check("t3_count0", 32'(count), 32'd0);

      // 4: empty drain from IDLE (stray ack held high is ignored)
      send_buf = 1'b1; tick(); send_buf = 1'b0;
      @(negedge clk);
      check("t4_rts_c1", 32'(request_to_send), 32'd0);
      check("t4_complete_c1", 32'(complete_data), 32'd0);
      tick();
      @(negedge clk);
      check("t4_complete_c2", 32'(complete_data), 32'd1);
      check("t4_rts_c2", 32'(request_to_send), 32'd0);
      tick();
      @(negedge clk);
      check("t4_complete_c3", 32'(complete_data), 32'd0);
      check("t4_ready", 32'(ready), 32'd1);
      ack = 1'b0;

      // 5: trig edge together with send_buf while RUNNING, timer keeps running
      start = 1'b1; tick(); start = 1'b0;
      repeat (4) tick();
      pulse_trig();
      push_ts(32'd4); push_ts(32'd6);
      trig = 1'b1; send_buf = 1'b1; ack = 1'b1; tick();
      trig = 1'b0; send_buf = 1'b0;
      @(negedge clk);
      check("t5_rts", 32'(request_to_send), 32'd1);
      wait_complete("t5_complete", 20);
      tick();
      @(negedge clk);
      check("t5_running", 32'(running), 32'd1);
      check("t5_ready", 32'(ready), 32'd1);
      trig = 1'b1; tick(); trig = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      @(negedge clk);
      check("t5_count1", 32'(count), 32'd1);
      push_ts(32'h10);
      send_buf = 1'b1; tick(); send_buf = 1'b0;
      wait_complete("t5_complete2", 20);
      check("t5_q_empty", 32'(exp_q.size()), 32'd0);
      tick();
      ack = 1'b0;

      // 6: reset during the second byte aborts the drain
      start = 1'b1; tick(); start = 1'b0;
      repeat (7) tick();
      pulse_trig();
      stop = 1'b1; tick(); stop = 1'b0;
      exp_q.push_back(8'h00);
      ack = 1'b1; send_buf = 1'b1; tick(); send_buf = 1'b0;
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      @(negedge clk);
      check("t6_rts", 32'(request_to_send), 32'd0);
      check("t6_count", 32'(count), 32'd0);
      check("t6_ready", 32'(ready), 32'd1);
      check("t6_complete", 32'(complete_data), 32'd0);
      check("t6_running", 32'(running), 32'd0);
      check("t6_q_empty", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         check("t6_no_complete", 32'(complete_data), 32'd0);
      end
      ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
